// File: rtl/fsm_state_tracker_pkg.sv
// ---------------------------------------------------------------------------
// fsm_state_tracker_pkg: shared widths, state encodings, field offsets. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fsm_state_tracker_pkg;

  localparam int STATE_W = 3;

  // Encodings of the observed FSM, shared with the FSM block so both sides agree.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6,
    ST_HALT = 3'd7
  } fsm_state_e;

  typedef enum logic [0:0] {
    TRK_UNPRIMED = 1'b0,
    TRK_PRIMED   = 1'b1
  } trk_state_e;

  // History entry layout: {state, dwell}; dwell occupies [dwell_w-1:0].
  function automatic int state_lsb(input int dwell_w);
    return dwell_w;
  endfunction

  function automatic int entry_w(input int dwell_w);
    return STATE_W + dwell_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_state_tracker_if.sv
// ---------------------------------------------------------------------------
// fsm_state_tracker_if: history FIFO read bus between host and tracker. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fsm_state_tracker_if
  import fsm_state_tracker_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8
) ();

  localparam int ENTRY_W = entry_w(DWELL_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               rd_en;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid;
  logic               empty;
  logic               full;
  logic [LVL_W-1:0]   level;

  modport master (output rd_en, input rd_data, rd_valid, empty, full, level);
  modport slave  (input rd_en, output rd_data, rd_valid, empty, full, level);

endinterface

`default_nettype wire

// File: rtl/fsm_state_tracker_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo: registered-read FIFO with registered flags. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       wr_en,
  input  wire logic [WIDTH-1:0]           wr_data,
  input  wire logic                       rd_en,
  output logic      [WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  output logic                            empty,
  output logic                            full,
  output logic      [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_empty;
  logic             r_full;
  logic             w_do_rd;
  logic             w_do_wr;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  assign w_do_rd = rd_en && !r_empty;
  assign w_do_wr = wr_en && (!r_full || w_do_rd);

  always_comb begin
    w_level_nxt = r_level;
    if (w_do_wr && !w_do_rd) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_do_wr && w_do_rd) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_do_rd;
      if (w_do_rd) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(DEPTH));
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign empty    = r_empty;
  assign full     = r_full;
  assign level    = r_level;

endmodule

`default_nettype wire

// File: rtl/fsm_state_tracker.sv
// ---------------------------------------------------------------------------
// fsm_state_tracker: per-state dwell, transition count, visit history. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fsm_state_tracker
  import fsm_state_tracker_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8,
  parameter int TCNT_W  = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic [STATE_W-1:0] state_in,
  fsm_state_tracker_if.slave      hist,
  output logic      [STATE_W-1:0] cur_state,
  output logic      [DWELL_W-1:0] dwell,
  output logic      [TCNT_W-1:0]  trans_count,
  output logic                    overflow
);

  localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

  trk_state_e         r_trk;
  trk_state_e         w_trk_nxt;
  logic               w_push;
  logic               w_drop;
  logic [STATE_W-1:0] r_cur_state;
  logic [DWELL_W-1:0] r_dwell;
  logic [TCNT_W-1:0]  r_trans;
  logic               r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_trk <= TRK_UNPRIMED;
    end else begin
      r_trk <= w_trk_nxt;
    end
  end

  always_comb begin
    w_trk_nxt = r_trk;
    w_push    = 1'b0;
    case (r_trk)
      TRK_UNPRIMED: w_trk_nxt = TRK_PRIMED;
      TRK_PRIMED:   w_push    = (state_in != r_cur_state);
      default:      w_trk_nxt = TRK_UNPRIMED;
    endcase
  end

  // Full is never set while empty, so a host pop alone guarantees room.
  assign w_drop = w_push && hist.full && !hist.rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_state <= '0;
      r_dwell     <= '0;
      r_trans     <= '0;
      r_overflow  <= 1'b0;
    end else if (r_trk == TRK_UNPRIMED) begin
      r_cur_state <= state_in;
      r_dwell     <= DWELL_W'(1);
    end else if (w_push) begin
      r_cur_state <= state_in;
      r_dwell     <= DWELL_W'(1);
      r_trans     <= r_trans + TCNT_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end else if (r_dwell != DWELL_MAX) begin
      r_dwell <= r_dwell + DWELL_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (entry_w(DWELL_W)),
    .DEPTH (DEPTH)
  ) u_hist_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (w_push),
    .wr_data  ({r_cur_state, r_dwell}),
    .rd_en    (hist.rd_en),
    .rd_data  (hist.rd_data),
    .rd_valid (hist.rd_valid),
    .empty    (hist.empty),
    .full     (hist.full),
    .level    (hist.level)
  );

  assign cur_state   = r_cur_state;
  assign dwell       = r_dwell;
  assign trans_count = r_trans;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire
